// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and helpers for the memory-access stage.
//   state_t          : FSM states of mem_access
//   LD_* / ST_*      : bit positions in the one-hot load / store format vectors
//   store_be()       : byte enables for a store of given width and address
//   store_lanes()    : store data replicated across the byte lanes
//   misaligned()     : alignment check used when MISALIGN_TRAP_EN is defined
// Lane helpers assume a 32-bit data bus.
// -----------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // load format one-hot {LHU,LBU,LW,LH,LB}
    localparam int LD_LB  = 0;
    localparam int LD_LH  = 1;
    localparam int LD_LW  = 2;
    localparam int LD_LBU = 3;
    localparam int LD_LHU = 4;

    // store format one-hot {SW,SH,SB}
    localparam int ST_SB = 0;
    localparam int ST_SH = 1;
    localparam int ST_SW = 2;

    // Half-word lanes only ever start at byte 0 or 2, so addr[0] is dropped.
    function automatic logic [3:0] store_be(input logic [2:0] fmt, input logic [1:0] addr_lo);
        logic [3:0] be;
        if (fmt[ST_SB])
            be = 4'b0001 << addr_lo;
        else if (fmt[ST_SH])
            be = 4'b0011 << {addr_lo[1], 1'b0};
        else
            be = 4'b1111;
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] fmt, input logic [31:0] data);
        logic [31:0] lanes;
        if (fmt[ST_SB])
            lanes = {4{data[7:0]}};
        else if (fmt[ST_SH])
            lanes = {2{data[15:0]}};
        else
            lanes = data;
        return lanes;
    endfunction

    function automatic logic misaligned(input logic       is_store,
                                        input logic [2:0] st_fmt,
                                        input logic [4:0] ld_fmt,
                                        input logic [1:0] addr_lo);
        logic half;
        logic word;
        if (is_store) begin
            half = st_fmt[ST_SH];
            word = st_fmt[ST_SW];
        end else begin
            half = ld_fmt[LD_LH] | ld_fmt[LD_LHU];
            word = ld_fmt[LD_LW];
        end
        return (half & addr_lo[0]) | (word & (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_load_formatter.sv
// -----------------------------------------------------------------------------
// mem_access_load_formatter
// Combinational lane select and sign/zero extension of a loaded word.
// Ports:
//   rdata   in  DW  raw read word from the data bus
//   addr_lo in  2   byte offset of the load
//   fmt     in  5   load format one-hot {LHU,LBU,LW,LH,LB}
//   data    out DW  write-back value
// An all-zero or unknown format passes the word through unchanged.
// -----------------------------------------------------------------------------
module mem_access_load_formatter
    import mem_access_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    addr_lo,
    input  logic [4:0]    fmt,
    output logic [DW-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // misaligned half-word loads are aligned down to the half-word
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        if (fmt[LD_LB])
            data = {{(DW-8){byte_sel[7]}}, byte_sel};
        else if (fmt[LD_LH])
            data = {{(DW-16){half_sel[15]}}, half_sel};
        else if (fmt[LD_LBU])
            data = {{(DW-8){1'b0}}, byte_sel};
        else if (fmt[LD_LHU])
            data = {{(DW-16){1'b0}}, half_sel};
    end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory stage: turns load/store pulses from execute into req/gnt/rvalid data
// bus transactions, stalls upstream with halt_o while a transaction is open,
// formats load data and forwards write-back to the register file. Non-memory
// write-backs pass through with one cycle of latency.
//
// Optional feature (macro MISALIGN_TRAP_EN): misaligned half/word accesses are
// rejected with bus_err_o instead of being aligned down.
//
// Ports:
//   clk_i, resetn_i                   clock, async active-low reset
//   mem_addr_i, mem_read_en_i,
//   mem_write_en_i, mem_write_fmt_i,
//   mem_write_data_i                  memory op from execute
//   rd_addr_i, rd_write_en_i,
//   rd_write_fmt_i, rd_data_i         write-back info from execute
//   dmem_req_o, dmem_we_o, dmem_addr_o,
//   dmem_be_o, dmem_wdata_o           data bus request side
//   dmem_gnt_i, dmem_rvalid_i,
//   dmem_rdata_i                      data bus response side
//   halt_o                            stall upstream
//   rd_addr_o, rd_write_en_o, rd_data_o   write-back to regfile
//   bus_err_o                         sticky timeout / misalign error
//
// state | meaning
// IDLE  | no open transaction; pass-through of non-memory write-back
// REQ   | request on the bus, waiting for gnt
// WAIT  | load granted, waiting for rvalid
// -----------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [DW-1:0]   mem_addr_i,
    input  logic            mem_read_en_i,
    input  logic            mem_write_en_i,
    input  logic [2:0]      mem_write_fmt_i,
    input  logic [DW-1:0]   mem_write_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_write_en_i,
    input  logic [4:0]      rd_write_fmt_i,
    input  logic [DW-1:0]   rd_data_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [DW-1:0]   dmem_addr_o,
    output logic [DW/8-1:0] dmem_be_o,
    output logic [DW-1:0]   dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [DW-1:0]   dmem_rdata_i,
    output logic            halt_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_write_en_o,
    output logic [DW-1:0]   rd_data_o,
    output logic            bus_err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [1:0]    addr_lo_q;
    logic [4:0]    ld_fmt_q;
    logic [4:0]    rd_addr_q;
    logic [TW-1:0] tmo_cnt;
    logic [DW-1:0] ld_data;
    logic          mem_op;
    logic          misalign;

    assign mem_op = mem_read_en_i | mem_write_en_i;

`ifdef MISALIGN_TRAP_EN
    assign misalign = misaligned(mem_write_en_i, mem_write_fmt_i, rd_write_fmt_i, mem_addr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Combinational so upstream stalls in the very cycle the op is presented.
    assign halt_o = (state != IDLE) | mem_op;

    mem_access_load_formatter #(.DW(DW)) u_load_formatter (
        .rdata   (dmem_rdata_i),
        .addr_lo (addr_lo_q),
        .fmt     (ld_fmt_q),
        .data    (ld_data)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state         <= IDLE;
            addr_lo_q     <= '0;
            ld_fmt_q      <= '0;
            rd_addr_q     <= '0;
            tmo_cnt       <= '0;
            dmem_req_o    <= 1'b0;
            dmem_we_o     <= 1'b0;
            dmem_addr_o   <= '0;
            dmem_be_o     <= '0;
            dmem_wdata_o  <= '0;
            rd_addr_o     <= '0;
            rd_write_en_o <= 1'b0;
            rd_data_o     <= '0;
            bus_err_o     <= 1'b0;
        end else begin
            rd_write_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        if (misalign) begin
                            bus_err_o <= 1'b1;
                        end else begin
                            state       <= REQ;
                            dmem_req_o  <= 1'b1;
                            // store wins when both enables are high
                            dmem_we_o   <= mem_write_en_i;
                            dmem_addr_o <= {mem_addr_i[DW-1:2], 2'b00};
                            if (mem_write_en_i) begin
                                dmem_be_o    <= store_be(mem_write_fmt_i, mem_addr_i[1:0]);
                                dmem_wdata_o <= store_lanes(mem_write_fmt_i, mem_write_data_i);
                            end else begin
                                dmem_be_o    <= '1;
                                dmem_wdata_o <= '0;
                            end
                            addr_lo_q <= mem_addr_i[1:0];
                            ld_fmt_q  <= rd_write_fmt_i;
                            rd_addr_q <= rd_addr_i;
                            tmo_cnt   <= TW'(TIMEOUT - 1);
                        end
                    end else begin
                        rd_addr_o     <= rd_addr_i;
                        rd_data_o     <= rd_data_i;
                        rd_write_en_o <= rd_write_en_i;
                    end
                end

                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (dmem_we_o) begin
                            state <= IDLE;
                        end else if (dmem_rvalid_i) begin
                            state         <= IDLE;
                            rd_addr_o     <= rd_addr_q;
                            rd_data_o     <= ld_data;
                            rd_write_en_o <= (rd_addr_q != 5'd0);
                        end else begin
                            state   <= WAIT;
                            tmo_cnt <= tmo_cnt - 1'b1;
                        end
                    end else if (tmo_cnt == '0) begin
                        state      <= IDLE;
                        dmem_req_o <= 1'b0;
                        bus_err_o  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end

                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state         <= IDLE;
                        rd_addr_o     <= rd_addr_q;
                        rd_data_o     <= ld_data;
                        rd_write_en_o <= (rd_addr_q != 5'd0);
                    end else if (tmo_cnt == '0) begin
                        state     <= IDLE;
                        bus_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    dmem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Directed bench for mem_access. Expected bus requests and write-backs are
// queued when an operation is driven and compared as the DUT produces them.
// Honours MISALIGN_TRAP_EN for the misaligned-access expectations.
// -----------------------------------------------------------------------------
module tb_mem_access;

    logic        clk;
    logic        resetn;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [2:0]  mem_write_fmt;
    logic [31:0] mem_write_data;
    logic [4:0]  rd_addr;
    logic        rd_write_en;
    logic [4:0]  rd_write_fmt;
    logic [31:0] rd_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        halt;
    logic [4:0]  rd_addr_out;
    logic        rd_write_en_out;
    logic [31:0] rd_data_out;
    logic        bus_err;

    mem_access #(.DW(32), .TIMEOUT(255)) dut (
        .clk_i            (clk),
        .resetn_i         (resetn),
        .mem_addr_i       (mem_addr),
        .mem_read_en_i    (mem_read_en),
        .mem_write_en_i   (mem_write_en),
        .mem_write_fmt_i  (mem_write_fmt),
        .mem_write_data_i (mem_write_data),
        .rd_addr_i        (rd_addr),
        .rd_write_en_i    (rd_write_en),
        .rd_write_fmt_i   (rd_write_fmt),
        .rd_data_i        (rd_data),
        .dmem_req_o       (dmem_req),
        .dmem_we_o        (dmem_we),
        .dmem_addr_o      (dmem_addr),
        .dmem_be_o        (dmem_be),
        .dmem_wdata_o     (dmem_wdata),
        .dmem_gnt_i       (dmem_gnt),
        .dmem_rvalid_i    (dmem_rvalid),
        .dmem_rdata_i     (dmem_rdata),
        .halt_o           (halt),
        .rd_addr_o        (rd_addr_out),
        .rd_write_en_o    (rd_write_en_out),
        .rd_data_o        (rd_data_out),
        .bus_err_o        (bus_err)
    );

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    bus_exp_t bus_q[$];
    wb_t      wb_exp_q[$];
    wb_t      wb_obs_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (resetn && rd_write_en_out)
            wb_obs_q.push_back('{rd: rd_addr_out, data: rd_data_out});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bus(input bit req, input bit we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
        bus_q.push_back('{req: req, we: we, addr: addr, be: be, wdata: wdata});
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
        wb_exp_q.push_back('{rd: rd, data: data});
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        wb_t o;
        while (wb_exp_q.size() > 0) begin
            e = wb_exp_q.pop_front();
            chk({tag, " wb_present"}, 32'(wb_obs_q.size() > 0), 32'd1);
            if (wb_obs_q.size() > 0) begin
                o = wb_obs_q.pop_front();
                chk({tag, " wb_rd"}, 32'(o.rd), 32'(e.rd));
                chk({tag, " wb_data"}, o.data, e.data);
            end
        end
        chk({tag, " wb_extra"}, 32'(wb_obs_q.size()), 32'd0);
        wb_obs_q.delete();
    endtask

    // One memory op: accept cycle, then bus response driven cycle by cycle.
    // gnt arrives gnt_wait cycles after the first REQ cycle; rvalid rv_wait
    // cycles after gnt.
    task automatic do_op(input string tag, input logic rd_en, input logic wr_en,
                         input logic [31:0] addr, input logic [2:0] wfmt,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [4:0] rfmt, input int gnt_wait, input int rv_wait,
                         input logic [31:0] rdata, input int exp_halt);
        int       halt_cyc;
        bit       done;
        bus_exp_t e;
        @(posedge clk); #1;
        mem_addr       = addr;
        mem_read_en    = rd_en;
        mem_write_en   = wr_en;
        mem_write_fmt  = wfmt;
        mem_write_data = wdata;
        rd_addr        = rd;
        rd_write_fmt   = rfmt;
        halt_cyc = 0;
        @(negedge clk);
        if (halt) halt_cyc++;
        @(posedge clk); #1;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            dmem_gnt    = (c == gnt_wait);
            dmem_rvalid = rd_en && !wr_en && (c == gnt_wait + rv_wait);
            dmem_rdata  = rdata;
            @(negedge clk);
            if (c == 0) begin
                e = bus_q.pop_front();
                chk({tag, " req"}, 32'(dmem_req), 32'(e.req));
                if (e.req) begin
                    chk({tag, " we"}, 32'(dmem_we), 32'(e.we));
                    chk({tag, " addr"}, dmem_addr, e.addr);
                    chk({tag, " be"}, 32'(dmem_be), 32'(e.be));
                    if (e.we) chk({tag, " wdata"}, dmem_wdata, e.wdata);
                end
            end
            if (halt) begin
                halt_cyc++;
            end else begin
                done = 1'b1;
                break;
            end
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " halt_cycles"}, 32'(halt_cyc), 32'(exp_halt));
        @(posedge clk); #1;
        check_wb(tag);
    endtask

    initial begin
        resetn = 1'b0;
        mem_addr = '0; mem_read_en = 1'b0; mem_write_en = 1'b0;
        mem_write_fmt = '0; mem_write_data = '0;
        rd_addr = '0; rd_write_en = 1'b0; rd_write_fmt = '0; rd_data = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst halt", 32'(halt), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst wb_en", 32'(rd_write_en_out), 32'd0);
        chk("rst wb_data", rd_data_out, 32'd0);
        chk("rst be", 32'(dmem_be), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // non-memory write-back passes through with one cycle of latency
        @(posedge clk); #1;
        rd_write_en = 1'b1; rd_addr = 5'd5; rd_data = 32'h0000_1234;
        push_wb(5'd5, 32'h0000_1234);
        @(posedge clk); #1;
        rd_write_en = 1'b0;
        @(posedge clk); #1;
        check_wb("passthru");

        push_bus(1, 1, 32'h100, 4'b1111, 32'hDEADBEEF);
        do_op("sw", 0, 1, 32'h100, 3'b100, 32'hDEADBEEF, 5'd0, 5'd0, 1, 0, 32'h0, 3);

        push_bus(1, 1, 32'h100, 4'b1000, 32'hA5A5A5A5);
        do_op("sb", 0, 1, 32'h103, 3'b001, 32'h0000_00A5, 5'd0, 5'd0, 0, 0, 32'h0, 2);

        push_bus(1, 1, 32'h104, 4'b1100, 32'hBEEFBEEF);
        do_op("sh", 0, 1, 32'h106, 3'b010, 32'h1234BEEF, 5'd0, 5'd0, 0, 0, 32'h0, 2);

        push_bus(1, 0, 32'h100, 4'b1111, 32'h0);
        push_wb(5'd7, 32'hFFFFFF80);
        do_op("lb", 1, 0, 32'h102, 3'b000, 32'h0, 5'd7, 5'b00001, 0, 1, 32'h0080_0000, 3);

        push_bus(1, 0, 32'h100, 4'b1111, 32'h0);
        push_wb(5'd7, 32'h0000_0080);
        do_op("lbu", 1, 0, 32'h102, 3'b000, 32'h0, 5'd7, 5'b01000, 0, 1, 32'h0080_0000, 3);

        // gnt and rvalid together: REQ returns straight to IDLE
        push_bus(1, 0, 32'h100, 4'b1111, 32'h0);
        push_wb(5'd8, 32'hFFFF8001);
        do_op("lh", 1, 0, 32'h102, 3'b000, 32'h0, 5'd8, 5'b00010, 0, 0, 32'h8001_0000, 2);

        push_bus(1, 0, 32'h100, 4'b1111, 32'h0);
        push_wb(5'd9, 32'h0000_9ABC);
        do_op("lhu", 1, 0, 32'h102, 3'b000, 32'h0, 5'd9, 5'b10000, 1, 2, 32'h9ABC_1234, 5);

        // load to x0: bus access happens but nothing is written back
        push_bus(1, 0, 32'h104, 4'b1111, 32'h0);
        do_op("lw_x0", 1, 0, 32'h104, 3'b000, 32'h0, 5'd0, 5'b00100, 0, 0, 32'hCAFEF00D, 2);

        // both enables: store wins, load dropped
        push_bus(1, 1, 32'h108, 4'b1111, 32'h0BADF00D);
        do_op("ld_st", 1, 1, 32'h108, 3'b100, 32'h0BADF00D, 5'd4, 5'b00100, 0, 0, 32'h1111_1111, 2);
        chk("ld_st bus_err", 32'(bus_err), 32'd0);

        // no gnt: 255 cycles in REQ, then error and release
        push_bus(1, 1, 32'h200, 4'b1111, 32'h1234_5678);
        do_op("timeout", 0, 1, 32'h200, 3'b100, 32'h1234_5678, 5'd0, 5'd0, 1000, 0, 32'h0, 256);
        chk("timeout bus_err", 32'(bus_err), 32'd1);
        chk("timeout req", 32'(dmem_req), 32'd0);

        // reset while waiting for rvalid drops the load
        @(posedge clk); #1;
        mem_read_en = 1'b1; mem_addr = 32'h300; rd_write_fmt = 5'b00100; rd_addr = 5'd10;
        @(posedge clk); #1;
        mem_read_en = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk("wait req", 32'(dmem_req), 32'd0);
        chk("wait halt", 32'(halt), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("midrst halt", 32'(halt), 32'd0);
        chk("midrst bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("postrst halt", 32'(halt), 32'd0);
        @(posedge clk); #1;
        check_wb("postrst");

        // misaligned word load
`ifdef MISALIGN_TRAP_EN
        push_bus(0, 0, 32'h0, 4'b0000, 32'h0);
        do_op("lw_mis", 1, 0, 32'h101, 3'b000, 32'h0, 5'd3, 5'b00100, 0, 0, 32'h1122_3344, 1);
        chk("lw_mis bus_err", 32'(bus_err), 32'd1);
`else
        push_bus(1, 0, 32'h100, 4'b1111, 32'h0);
        push_wb(5'd3, 32'h1122_3344);
        do_op("lw_mis", 1, 0, 32'h101, 3'b000, 32'h0, 5'd3, 5'b00100, 0, 0, 32'h1122_3344, 2);
        chk("lw_mis bus_err", 32'(bus_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
